// File: rtl/classify_sequencer_if.sv
// Handshake and data bundle between the classification sequencer and its
// neighbours: the shared output-layer neuron unit, the argmax selector and
// the result consumer.
//   master : the sequencer (issues neuron requests and selector launches, presents the result)
//   slave  : the environment (neuron unit, selector, start source, result consumer)
interface classify_sequencer_if #(
    parameter int unsigned SCORE_W     = 26,
    parameter int unsigned NUM_CLASSES = 10
);
    logic                           start;
    logic                           busy;
    logic                           neu_req;
    logic [3:0]                     neu_class;
    logic                           neu_done;
    logic [SCORE_W-1:0]             neu_score;
    logic [NUM_CLASSES*SCORE_W-1:0] score_bus;
    logic                           sel_start;
    logic                           sel_valid;
    logic [3:0]                     sel_num;
    logic                           img_valid;
    logic [3:0]                     img_num;
    logic                           img_ready;
    logic                           err;

    modport master (
        input  start, neu_done, neu_score, sel_valid, sel_num, img_ready,
        output busy, neu_req, neu_class, score_bus, sel_start, img_valid, img_num, err
    );

    modport slave (
        output start, neu_done, neu_score, sel_valid, sel_num, img_ready,
        input  busy, neu_req, neu_class, score_bus, sel_start, img_valid, img_num, err
    );
endinterface

// File: rtl/classify_sequencer.sv
// Per-image scheduler: walks the class indices through the shared neuron
// unit one request at a time, buffers the returned scores, launches the
// argmax selector on the buffered bank and presents the winning digit on a
// valid/ready port. A watchdog aborts to IDLE with a sticky err flag if the
// neuron unit or the selector fails to answer within TIMEOUT cycles.
// Ports:
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : classify_sequencer_if master side (start/busy, neuron
//              req/done/score, score bank bus, selector start/valid/num,
//              img valid/ready/num, err)
module classify_sequencer #(
    parameter int unsigned SCORE_W     = 26,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    classify_sequencer_if.master  bus
);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_N, S_SEL, S_WAIT_S, S_OUT
    } state_t;

    state_t              state_q, state_nxt;
    logic [IDX_W-1:0]    idx_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic [SCORE_W-1:0]  bank_q [NUM_CLASSES];
    logic [3:0]          img_num_q;
    logic                err_q;
    logic                busy_q, neu_req_q, sel_start_q, img_valid_q;
    logic                busy_d, neu_req_d, sel_start_d, img_valid_d;
    logic                wdog_expired_c;
    logic [NUM_CLASSES*SCORE_W-1:0] score_bus_c;

    assign wdog_expired_c = (wdog_q == WDOG_LAST);

    // State register plus the registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            neu_req_q   <= 1'b0;
            sel_start_q <= 1'b0;
            img_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            busy_q      <= busy_d;
            neu_req_q   <= neu_req_d;
            sel_start_q <= sel_start_d;
            img_valid_q <= img_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_nxt = S_REQ;
            S_REQ:    state_nxt = S_WAIT_N;
            S_WAIT_N: begin
                if (bus.neu_done) state_nxt = (idx_q == LAST_IDX) ? S_SEL : S_REQ;
                else if (wdog_expired_c) state_nxt = S_IDLE;
            end
            S_SEL:    state_nxt = S_WAIT_S;
            S_WAIT_S: begin
                if (bus.sel_valid) state_nxt = S_OUT;
                else if (wdog_expired_c) state_nxt = S_IDLE;
            end
            S_OUT:    if (bus.img_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        busy_d      = 1'b0;
        neu_req_d   = 1'b0;
        sel_start_d = 1'b0;
        img_valid_d = 1'b0;
        busy_d      = (state_nxt != S_IDLE);
        neu_req_d   = (state_nxt == S_REQ);
        sel_start_d = (state_nxt == S_SEL);
        img_valid_d = (state_nxt == S_OUT);
    end

    // Class index, watchdog, score bank, result digit and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            wdog_q    <= '0;
            img_num_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_CLASSES); i++) bank_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        idx_q  <= '0;
                        wdog_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                S_REQ, S_SEL: wdog_q <= '0;
                S_WAIT_N: begin
                    if (bus.neu_done) begin
                        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                            if (idx_q == IDX_W'(i)) bank_q[i] <= bus.neu_score;
                        end
                        if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
                    end else if (wdog_expired_c) begin
                        err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                end
                S_WAIT_S: begin
                    if (bus.sel_valid) begin
                        img_num_q <= bus.sel_num;
                    end else if (wdog_expired_c) begin
                        err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bank packed class-major onto the selector bus; stays put from SEL until the next start
    always_comb begin
        score_bus_c = '0;
        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            score_bus_c[i*SCORE_W +: SCORE_W] = bank_q[i];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.neu_req   = neu_req_q;
    assign bus.neu_class = idx_q;
    assign bus.score_bus = score_bus_c;
    assign bus.sel_start = sel_start_q;
    assign bus.img_valid = img_valid_q;
    assign bus.img_num   = img_num_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_classify_sequencer.sv
// Scoreboard bench for classify_sequencer: directed runs push the expected
// neuron request classes, selector bus snapshots and result digits into
// queues; a monitor pops and compares whenever the DUT presents them.
module tb_classify_sequencer;
    localparam int unsigned SCORE_W     = 26;
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned TIMEOUT     = 1024;
    localparam int          SEL_LAT     = 4;
    localparam int          BUS_W       = NUM_CLASSES * SCORE_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    classify_sequencer_if #(.SCORE_W(SCORE_W), .NUM_CLASSES(NUM_CLASSES)) ifc ();

    classify_sequencer #(
        .SCORE_W(SCORE_W), .NUM_CLASSES(NUM_CLASSES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    // Model outputs and spurious-pulse injectors are merged onto the interface
    logic               nd_model = 1'b0, nd_spur = 1'b0;
    logic               sv_model = 1'b0, sv_spur = 1'b0;
    logic [SCORE_W-1:0] ns_model = '0;
    logic [3:0]         sn_model = '0;
    assign ifc.neu_done  = nd_model | nd_spur;
    assign ifc.neu_score = nd_spur ? SCORE_W'('h1234) : ns_model;
    assign ifc.sel_valid = sv_model | sv_spur;
    assign ifc.sel_num   = sv_spur ? 4'd7 : sn_model;

    logic signed [SCORE_W-1:0] scores [NUM_CLASSES];
    int drop_class = -1;
    int t0 = 0;
    int n_vec = 0;
    int n_err = 0;

    int               exp_cls [$];
    logic [BUS_W-1:0] exp_bus [$];
    logic [3:0]       exp_num [$];

    function automatic logic [BUS_W-1:0] pack_scores();
        logic [BUS_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CLASSES; i++) v[i*SCORE_W +: SCORE_W] = scores[i];
        return v;
    endfunction

    // Neuron unit: answers one cycle after each request unless the class is withheld
    initial begin
        int cls;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ifc.neu_req === 1'b1 && int'(ifc.neu_class) != drop_class) begin
                cls = int'(ifc.neu_class);
                @(posedge clk); #1;
                nd_model = 1'b1;
                ns_model = scores[cls];
                @(posedge clk); #1;
                nd_model = 1'b0;
            end
        end
    end

    // Argmax selector: first strict maximum of the bus sampled at launch
    initial begin
        logic signed [SCORE_W-1:0] v, bv;
        int best;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ifc.sel_start === 1'b1) begin
                best = 0;
                bv   = ifc.score_bus[0 +: SCORE_W];
                for (int i = 1; i < NUM_CLASSES; i++) begin
                    v = ifc.score_bus[i*SCORE_W +: SCORE_W];
                    if (v > bv) begin bv = v; best = i; end
                end
                repeat (SEL_LAT + 1) @(posedge clk);
                #1;
                sv_model = 1'b1;
                sn_model = 4'(best);
                @(posedge clk); #1;
                sv_model = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_run(input int ncls, input bit to_sel, input logic [3:0] num);
        for (int i = 0; i < ncls; i++) exp_cls.push_back(i);
        if (to_sel) begin
            exp_bus.push_back(pack_scores());
            exp_num.push_back(num);
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        ifc.start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        ifc.start = 1'b0;
    endtask

    task automatic wait_img(input int lim);
        while (ifc.img_valid !== 1'b1 && (cyc - t0) < lim) @(negedge clk);
        chk("img_valid_seen", 32'(ifc.img_valid), 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        @(negedge clk);
        while (ifc.busy !== 1'b0 && (cyc - t0) < lim) @(negedge clk);
        chk("busy_low", 32'(ifc.busy), 32'd0);
        chk("img_valid_low", 32'(ifc.img_valid), 32'd0);
    endtask

    task automatic wait_req(input int cls, input int lim);
        while (!(ifc.neu_req === 1'b1 && int'(ifc.neu_class) == cls) && (cyc - t0) < lim)
            @(negedge clk);
        chk($sformatf("neu_req_class%0d_seen", cls), 32'(ifc.neu_req), 32'd1);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < NUM_CLASSES; i++) scores[i] = SCORE_W'(i * 100);
    endtask

    // Pops the scoreboard whenever the DUT presents a request, launch or result
    task automatic monitor();
        int e;
        logic [BUS_W-1:0] eb;
        logic [3:0] en;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (ifc.neu_req === 1'b1) begin
                    n_vec++;
                    if (exp_cls.size() == 0) begin
                        n_err++;
                        $display("FAIL neu_req_unexpected: got class %0d expected no request", ifc.neu_class);
                    end else begin
                        e = exp_cls.pop_front();
                        if (int'(ifc.neu_class) != e) begin
                            n_err++;
                            $display("FAIL neu_class: got %0d expected %0d", ifc.neu_class, e);
                        end
                    end
                end
                if (ifc.sel_start === 1'b1) begin
                    n_vec++;
                    if (exp_bus.size() == 0) begin
                        n_err++;
                        $display("FAIL sel_start_unexpected: got pulse expected none");
                    end else begin
                        eb = exp_bus.pop_front();
                        if (ifc.score_bus !== eb) begin
                            n_err++;
                            $display("FAIL score_bus: got %h expected %h", ifc.score_bus, eb);
                        end
                    end
                end
                if (ifc.img_valid === 1'b1 && ifc.img_ready === 1'b1) begin
                    n_vec++;
                    if (exp_num.size() == 0) begin
                        n_err++;
                        $display("FAIL img_unexpected: got digit %0d expected no result", ifc.img_num);
                    end else begin
                        en = exp_num.pop_front();
                        if (ifc.img_num !== en) begin
                            n_err++;
                            $display("FAIL img_num: got %0d expected %0d", ifc.img_num, en);
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_tests();
        logic [SCORE_W-1:0] slot, ev;
        bit ok;

        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.img_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_img_valid", 32'(ifc.img_valid), 32'd0);
        chk("rst_err", 32'(ifc.err), 32'd0);
        chk("rst_bus_zero", 32'(ifc.score_bus == '0), 32'd1);
        rst = 1'b0;

        // Ramp scores: ten requests, one launch, result after 27 cycles
        set_ramp();
        push_run(10, 1'b1, 4'd9);
        ifc.img_ready = 1'b1;
        start_pulse();
        wait_img(200);
        chk("latency_ramp", 32'(cyc - t0), 32'd27);
        wait_idle(300);

        // All-negative scores: winner is the least negative, slots packed verbatim
        scores = '{-26'sd5, -26'sd3, -26'sd8, -26'sd1, -26'sd9,
                   -26'sd2, -26'sd7, -26'sd6, -26'sd4, -26'sd10};
        push_run(10, 1'b1, 4'd3);
        start_pulse();
        wait_img(200);
        chk("latency_neg", 32'(cyc - t0), 32'd27);
        slot = ifc.score_bus[3*SCORE_W +: SCORE_W];
        chk("slot3_all_ones", 32'(slot), 32'h03FF_FFFF);
        for (int i = 0; i < NUM_CLASSES; i++) begin
            slot = ifc.score_bus[i*SCORE_W +: SCORE_W];
            ev   = scores[i];
            chk($sformatf("neg_slot%0d", i), 32'(slot), 32'(ev));
        end
        wait_idle(300);

        // Stray neuron strobe while idle leaves the bank and state alone
        @(posedge clk); #1; nd_spur = 1'b1;
        @(posedge clk); #1; nd_spur = 1'b0;
        @(negedge clk);
        chk("spur_done_busy", 32'(ifc.busy), 32'd0);
        chk("spur_done_bank", 32'(ifc.score_bus == pack_scores()), 32'd1);

        // Consumer stalls 50 cycles while start toggles; then ready and start together
        for (int i = 0; i < NUM_CLASSES; i++) scores[i] = '0;
        scores[6] = 26'sd50;
        push_run(10, 1'b1, 4'd6);
        ifc.img_ready = 1'b0;
        start_pulse();
        wait_img(200);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1; ifc.start = ~ifc.start;
            @(negedge clk);
            if (ifc.img_valid !== 1'b1 || ifc.img_num !== 4'd6 || ifc.busy !== 1'b1) ok = 1'b0;
        end
        chk("stall_hold", 32'(ok), 32'd1);
        @(posedge clk); #1; ifc.img_ready = 1'b1; ifc.start = 1'b1;
        @(posedge clk); #1; ifc.img_ready = 1'b0; ifc.start = 1'b0;
        @(negedge clk);
        chk("handshake_idle", 32'(ifc.busy), 32'd0);
        chk("handshake_valid_low", 32'(ifc.img_valid), 32'd0);
        chk("img_num_retained", 32'(ifc.img_num), 32'd6);
        repeat (3) @(negedge clk);
        chk("start_ignored", 32'(ifc.busy), 32'd0);

        // Class 5 never answers: watchdog fires after TIMEOUT cycles in WAIT_N
        set_ramp();
        drop_class = 5;
        push_run(6, 1'b0, 4'd0);
        ifc.img_ready = 1'b1;
        start_pulse();
        wait_req(5, 100);
        @(posedge clk); #1; sv_spur = 1'b1;
        @(posedge clk); #1; sv_spur = 1'b0;
        @(negedge clk);
        chk("spur_sel_busy", 32'(ifc.busy), 32'd1);
        chk("spur_sel_class", 32'(ifc.neu_class), 32'd5);
        chk("spur_sel_no_result", 32'(ifc.img_valid), 32'd0);
        repeat (TIMEOUT - 2) @(negedge clk);
        chk("wdog_last_err", 32'(ifc.err), 32'd0);
        chk("wdog_last_busy", 32'(ifc.busy), 32'd1);
        @(negedge clk);
        chk("wdog_err", 32'(ifc.err), 32'd1);
        chk("wdog_idle", 32'(ifc.busy), 32'd0);
        chk("wdog_slot4", 32'(ifc.score_bus[4*SCORE_W +: SCORE_W]), 32'd400);
        chk("wdog_slot6_kept", 32'(ifc.score_bus[6*SCORE_W +: SCORE_W]), 32'd50);

        // Next start clears err and completes normally
        drop_class = -1;
        push_run(10, 1'b1, 4'd9);
        start_pulse();
        @(negedge clk);
        chk("err_cleared", 32'(ifc.err), 32'd0);
        wait_img(200);
        wait_idle(300);

        // Asynchronous reset in the middle of WAIT_N for class 6
        drop_class = 6;
        push_run(7, 1'b0, 4'd0);
        start_pulse();
        wait_req(6, 100);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(ifc.busy), 32'd0);
        chk("arst_neu_req", 32'(ifc.neu_req), 32'd0);
        chk("arst_neu_class", 32'(ifc.neu_class), 32'd0);
        chk("arst_sel_start", 32'(ifc.sel_start), 32'd0);
        chk("arst_img_valid", 32'(ifc.img_valid), 32'd0);
        chk("arst_img_num", 32'(ifc.img_num), 32'd0);
        chk("arst_err", 32'(ifc.err), 32'd0);
        chk("arst_bank", 32'(ifc.score_bus == '0), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drop_class = -1;
        push_run(10, 1'b1, 4'd9);
        start_pulse();
        wait_img(200);
        chk("latency_after_rst", 32'(cyc - t0), 32'd27);
        wait_idle(300);

        repeat (3) @(negedge clk);
        chk("req_queue_drained", 32'(exp_cls.size()), 32'd0);
        chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        chk("num_queue_drained", 32'(exp_num.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
            begin
                repeat (20000) @(posedge clk);
                n_vec++;
                n_err++;
                $display("FAIL global_cycle_budget: got 20000 cycles expected completion");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/classify_sequencer.md
Name: classify_sequencer

Overview:
Top-level scheduler for one image classification. On `start` it time-multiplexes the shared output-layer neuron unit over the NUM_CLASSES class indices, one request at a time. It buffers each returned score in a register bank and then launches the downstream argmax selector. It captures the winning digit and presents it on a valid/ready result port. A watchdog flags a hung neuron unit or selector.

Parameters:
SCORE_W, 26, width of one signed class score (two's complement)
NUM_CLASSES, 10, number of output classes (4-bit class index, so ≤16)
TIMEOUT, 1024, max cycles to wait for neu_done or sel_valid before error

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin classifying current image; accepted only in IDLE
busy  out  1  high in every state except IDLE
neu_req  out  1  1-cycle request pulse to shared neuron unit
neu_class  out  4  class index for neu_req; held stable until neu_done
neu_done  in  1  neuron unit result strobe (1 cycle)
neu_score  in  SCORE_W  signed score, valid with neu_done
score_bus  out  NUM_CLASSES*SCORE_W  buffered scores; class i at [i*SCORE_W +: SCORE_W], feeds selector s0..s9
sel_start  out  1  1-cycle launch pulse to selector Input_Valid
sel_valid  in  1  selector result strobe
sel_num  in  4  selector winning index, valid with sel_valid
img_valid  out  1  result available
img_num  out  4  classified digit
img_ready  in  1  consumer accepts result
err  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): state=IDLE, idx=0, wdog=0, score bank=0. Outputs: busy=0, neu_req=0, neu_class=0, sel_start=0, img_valid=0, img_num=0, err=0. All registers clear on assertion, not at the next edge.
- FSM states: IDLE, REQ, WAIT_N, SEL, WAIT_S, OUT.
- IDLE:
  - start=1 → REQ; idx=0; err cleared; wdog=0.
  - start in any other state is ignored, with no queuing.
- REQ:
  - neu_req=1 for exactly this cycle; neu_class=idx; wdog=0.
  - → WAIT_N.
- WAIT_N:
  - neu_done=1 → bank[idx]=neu_score.
  - If idx==NUM_CLASSES-1 → SEL; else idx+1 and → REQ.
  - Otherwise wdog+1; if wdog==TIMEOUT-1 → err=1, → IDLE, bank untouched.
  - neu_done outside WAIT_N is ignored.
- SEL:
  - sel_start=1 for exactly this cycle; wdog=0.
  - → WAIT_S.
- WAIT_S:
  - sel_valid=1 → img_num=sel_num, → OUT.
  - Otherwise wdog+1; timeout as in WAIT_N.
  - sel_valid outside WAIT_S is ignored.
- OUT:
  - img_valid=1; img_num held stable.
  - img_ready=1 → img_valid=0 next cycle, → IDLE.
  - Holds indefinitely while img_ready=0.
- score_bus:
  - Driven directly from the bank.
  - Stable from SEL until the next start, so the multi-cycle selector samples consistent data.
- Scores are stored verbatim; no arithmetic or sign-extension is applied.
- img_num retains its last value after handshake until overwritten.
- Latency with neuron latency Ln (req→done) and selector latency Ls (start→valid):
  - start accepted at cycle 0 → img_valid rises at cycle 1 + NUM_CLASSES*(1+Ln) + 1 + Ls + 1.
  - With Ln=1, Ls=4 (current selector): 27.
- img_ready high while not in OUT has no effect.
- start and img_ready in the same cycle while in OUT: the handshake completes, start is ignored, and the FSM returns to IDLE.

Test Plan:
- Reset then start, neuron returns score=class*100 (class 9 = 900) one cycle after each req, selector model returns max index 4 cycles after sel_start → exactly 10 neu_req pulses with neu_class 0..9, one sel_start, img_valid at cycle 27, img_num=9, busy low after img_ready.
- Scores {-5,-3,-8,-1,-9,-2,-7,-6,-4,-10} (signed, negative) → score_bus slot 3 = 26'h3FFFFFF; img_num=3; verify every slot packs correctly.
- Hold img_ready=0 for 50 cycles in OUT, toggle start → img_valid stays 1, img_num stable, no new neu_req; raise img_ready → IDLE next cycle.
- Withhold neu_done for class 5 → err=1 after TIMEOUT cycles in WAIT_N, FSM in IDLE, busy=0, no sel_start; next start clears err and completes normally.
- Assert rst asynchronously mid-WAIT_N (idx=6) between clock edges → all outputs 0 immediately; after release, start runs the full 10-class sequence from idx 0.
- Spurious neu_done in IDLE and sel_valid during WAIT_N → no bank write, no state change.
